// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC generation and instruction-bus control, sitting directly
// upstream of the fetch stage.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   ireq           instruction bus request {valid, addr}
//   iresp          instruction bus response {addr_ok, data_ok, data}
//   stall          downstream cannot accept the buffered instruction
//   redirect_valid redirect fetch to redirect_pc this cycle
//   redirect_pc    redirect target (bits [1:0] are cleared here)
//   pc             PC of the buffered instruction (always pc_q)
//   raw_instr      buffered instruction word
//   instr_valid    pc/raw_instr hold a valid, undiscarded instruction
//   dbg_state      current FSM state, for observation only
//
// Bus handshake: once ireq.valid is raised, valid and addr stay stable up to
// and including the cycle in which iresp.data_ok=1; that cycle completes the
// transfer. addr_ok carries no meaning for this block.

package ifetch_pkg;
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output ibus_req_t    ireq,
  input  ibus_resp_t   iresp,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic [63:0]  pc,
  output logic [31:0]  raw_instr,
  output logic         instr_valid,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         discard_q, discard_d;

  logic [63:0]  redirect_aligned;
  logic         unused_addr_ok;

  assign redirect_aligned = {redirect_pc[63:2], 2'b00};
  assign unused_addr_ok   = iresp.addr_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      tgt_q     <= 64'd0;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    discard_d = discard_q;

    unique case (state_q)
      ST_FETCH: begin
        if (iresp.data_ok) begin
          if (discard_q || redirect_valid) begin
            // The returning word belongs to a stale path: drop it and start
            // the request for the newest target on the following cycle.
            pc_d      = redirect_valid ? redirect_aligned : tgt_q;
            discard_d = 1'b0;
          end else begin
            instr_d = iresp.data;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // Request must stay stable until data_ok, so remember the target
          // and mark the in-flight response for discard. Latest wins.
          discard_d = 1'b1;
          tgt_d     = redirect_aligned;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_aligned;
          state_d = ST_FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          pc_d    = pc_q + 64'd4;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Reset gates valid combinationally so no request is shown while held.
  assign ireq.valid  = (state_q == ST_FETCH) && reset;
  assign ireq.addr   = pc_q;
  assign pc          = pc_q;
  assign raw_instr   = instr_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ibus_req_t    ireq;
  ibus_resp_t   iresp;
  logic         stall = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [63:0]  redirect_pc = 64'd0;
  logic [63:0]  pc;
  logic [31:0]  raw_instr;
  logic         instr_valid;
  fetch_state_t dbg_state;

  ifetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .raw_instr      (raw_instr),
    .instr_valid    (instr_valid),
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {pc, instr}
  logic [95:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 32'h0000_0013;
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // ---------------- memory responder ----------------
  // data_ok is raised once ireq.valid has been seen for mem_lat cycles.
  int mem_lat = 1;
  int mem_cnt = 0;
  initial iresp = '0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      iresp   = '0;
      mem_cnt = 0;
    end else begin
      if (iresp.data_ok) begin
        iresp.data_ok = 1'b0;
        mem_cnt       = 0;
      end
      iresp.addr_ok = ireq.valid;
      if (ireq.valid) begin
        if (mem_cnt >= mem_lat) begin
          iresp.data_ok = 1'b1;
          iresp.data    = mem_word(ireq.addr);
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // ---------------- delivery monitor ----------------
  logic prev_iv = 1'b0;
  always @(negedge clk) begin
    if (instr_valid && !prev_iv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {pc, raw_instr}, 96'd0);
      end else begin
        chk("delivery", {pc, raw_instr}, exp_q.pop_front());
      end
    end
    prev_iv <= instr_valid;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_delivery(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, {95'd0, got}, 96'd1);
  endtask

  // Checks the held address every cycle until data_ok is observed.
  task automatic hold_until_dok(input string tag, input logic [63:0] a);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk(tag, {31'd0, ireq.valid, ireq.addr}, {31'd0, 1'b1, a});
      if (iresp.data_ok) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_dok"}, {95'd0, seen}, 96'd1);
  endtask

  task automatic chk_req(input string tag, input logic [63:0] a);
    chk(tag, {31'd0, ireq.valid, ireq.addr}, {31'd0, 1'b1, a});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {95'd0, ireq.valid}, 96'd0);
    chk("rst_pc", {32'd0, pc}, {32'd0, RST_PC});
    chk("rst_raw", {64'd0, raw_instr}, 96'd0);
    chk("rst_iv", {95'd0, instr_valid}, 96'd0);

    // First fetch
    push_exp(RST_PC);
    reset = 1'b1;
    #1;
    chk_req("first_req", RST_PC);
    wait_delivery("first_deliver");
    chk("first_pc", {32'd0, pc}, {32'd0, RST_PC});
    chk("first_raw", {64'd0, raw_instr}, 96'h13);
    chk("hold_req_low", {95'd0, ireq.valid}, 96'd0);

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_held", {ireq.valid, instr_valid, pc, raw_instr},
          {1'b0, 1'b1, RST_PC, 32'h13});
    end
    stall = 1'b0;
    push_exp(64'h8000_0004);
    @(negedge clk);
    stall = 1'b1;
    chk_req("after_stall_req", 64'h8000_0004);
    chk("fetch_iv_low", {95'd0, instr_valid}, 96'd0);
    wait_delivery("deliver_04");

    // Redirect while 0x80000008 is outstanding (data_ok 3 cycles later)
    stall   = 1'b0;
    mem_lat = 3;
    @(negedge clk);
    stall = 1'b1;
    chk_req("req_08", 64'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    push_exp(64'h8000_1000);
    @(negedge clk);
    redirect_valid = 1'b0;
    hold_until_dok("held_08", 64'h8000_0008);
    @(negedge clk);
    chk_req("redir_req_1000", 64'h8000_1000);
    chk("redir_iv_low", {95'd0, instr_valid}, 96'd0);
    wait_delivery("deliver_1000");

    // Two redirects before data_ok: latest wins
    stall   = 1'b0;
    mem_lat = 4;
    @(negedge clk);
    stall = 1'b1;
    chk_req("req_1004", 64'h8000_1004);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    @(negedge clk);
    redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    hold_until_dok("held_1004", 64'h8000_1004);
    @(negedge clk);
    chk_req("latest_wins_200", 64'h200);

    // Redirect in the same cycle as data_ok
    hold_until_dok("held_200", 64'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h400;
    push_exp(64'h400);
    mem_lat = 1;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_req("same_cycle_req_400", 64'h400);
    chk("same_cycle_iv_low", {95'd0, instr_valid}, 96'd0);
    wait_delivery("deliver_400");

    // Redirect in HOLD while stalled
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    push_exp(64'h300);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("hold_redir_iv", {95'd0, instr_valid}, 96'd0);
    chk_req("hold_redir_req", 64'h300);
    wait_delivery("deliver_300");

    // Reset mid-request, then redirect to the top of the address space
    stall   = 1'b0;
    mem_lat = 3;
    @(negedge clk);
    stall = 1'b1;
    chk_req("req_304", 64'h304);
    reset = 1'b0;
    #1;
    chk("mid_rst_out", {ireq.valid, instr_valid, pc, raw_instr},
        {1'b0, 1'b0, RST_PC, 32'd0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_req("post_rst_req", RST_PC);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    mem_lat = 1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_delivery("deliver_top");
    stall = 1'b0;
    push_exp(64'd0);
    @(negedge clk);
    stall = 1'b1;
    chk_req("wrap_req_0", 64'd0);
    wait_delivery("deliver_0");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
